// File: rtl/bcd_to_binary_pkg.sv
// bcd_to_binary_pkg: shared BCD conversion defaults, digit type and FSM states
package bcd_to_binary_pkg;
  localparam int DIGITS_DEF = 6;
  localparam int BIN_W_DEF = 20;
  typedef logic [3:0] bcd_digit_t;
  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;
endpackage

// File: rtl/bcd_nibble_adjust.sv
// bcd_nibble_adjust: reverse double-dabble digit fixup, subtract 3 when >= 8
module bcd_nibble_adjust
  import bcd_to_binary_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);
  assign q = d >= 4'd8 ? d - 4'd3 : d;
endmodule

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential packed-BCD to binary converter (reverse double-dabble)
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF,
  parameter int OUT_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic [OUT_W-1:0]    binary_out,
  output logic                done,
  output logic                busy,
  output logic                err
);
  localparam int SR_W  = 4*DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr, t, sr_adj;
  logic [BIN_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [DIGITS-1:0] nib_bad;
  logic              bad, bad_q;
  assign t = sr >> 1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_nibble_adjust u_adj (.d(t[4*i+:4]), .q(sr_adj[4*i+:4]));
    assign nib_bad[i] = bcd_in[4*i+:4] > 4'd9;
  end
  assign bad = |nib_bad;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = bad ? FIN : CONV;
      CONV:    if (cnt == '0) state_d = FIN;
      default: state_d = IDLE;
    endcase
  end
  // Invalid input skips CONV entirely; bad_q steers FIN to report err
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr         <= '0;
      acc        <= '0;
      cnt        <= '0;
      bad_q      <= 1'b0;
      binary_out <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          sr    <= bcd_in;
          acc   <= '0;
          err   <= 1'b0;
          cnt   <= CNT_W'(BIN_W-1);
          busy  <= 1'b1;
          bad_q <= bad;
        end
        CONV: begin
          acc <= {sr[0], acc[BIN_W-1:1]};
          sr  <= sr_adj;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIN: begin
          binary_out <= bad_q ? '0 : OUT_W'(acc);
          err        <= bad_q;
          done       <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: directed vectors plus a decimal-arithmetic reference model checked every cycle
module tb_bcd_to_binary;
  localparam int BIN_W = 20;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] bcd_in = '0;
  logic [31:0] binary_out;
  logic        done, busy, err;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  bcd_to_binary dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .binary_out(binary_out), .done(done), .busy(busy), .err(err)
  );
  function automatic logic [31:0] bcd_value(input logic [23:0] b);
    int v = 0;
    int p = 1;
    for (int i = 0; i < 6; i++) begin
      v += int'(b[4*i+:4]) * p;
      p *= 10;
    end
    return v;
  endfunction
  function automatic logic bcd_invalid(input logic [23:0] b);
    logic r = 1'b0;
    for (int i = 0; i < 6; i++) r |= b[4*i+:4] > 4'd9;
    return r;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: a request either finishes BIN_W+1 edges after acceptance or, if invalid, one edge after
  logic        m_done, m_busy, m_err, m_inv;
  logic [31:0] m_out, m_val;
  int          m_rem;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_done <= 0; m_busy <= 0; m_err <= 0; m_inv <= 0;
      m_out <= 0; m_val <= 0; m_rem <= 0;
    end else begin
      m_done <= 0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1;
          m_err  <= 0;
          m_inv  <= bcd_invalid(bcd_in);
          m_val  <= bcd_value(bcd_in);
          m_rem  <= bcd_invalid(bcd_in) ? 1 : BIN_W + 1;
        end
      end else if (m_rem == 1) begin
        m_done <= 1;
        m_busy <= 0;
        m_out  <= m_inv ? 32'd0 : m_val;
        m_err  <= m_inv;
      end else m_rem <= m_rem - 1;
    end
  end
  always begin
    @(posedge clk);
    #1;
    check("cyc_done", done, m_done);
    check("cyc_busy", busy, m_busy);
    check("cyc_err", err, m_err);
    check("cyc_out", binary_out, m_out);
  end
  task automatic run_conv(input logic [23:0] b, input logic [31:0] exp, input logic exp_err, input int exp_lat);
    int k = 0;
    int nb = 0;
    bcd_in = b;
    start = 1;
    do begin
      @(negedge clk);
      start = 0;
      k++;
      if (busy) nb++;
    end while (!done && k < 40);
    check("latency", k, exp_lat);
    check("busy_cycles", nb, exp_lat - 1);
    check("result", binary_out, exp);
    check("err", err, exp_err);
    check("model_result", m_out, exp);
    @(negedge clk);
    check("done_pulse", done, 0);
  endtask
  initial begin
    int nd;
    int last;
    repeat (3) @(negedge clk);
    check("rst_out", binary_out, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst_n = 1;
    @(negedge clk);
    run_conv(24'h123456, 32'h0001E240, 0, 22);
    run_conv(24'h000000, 32'h00000000, 0, 22);
    run_conv(24'h999999, 32'h000F423F, 0, 22);
    run_conv(24'h000001, 32'h00000001, 0, 22);
    run_conv(24'h12A456, 32'h00000000, 1, 2);
    run_conv(24'h000010, 32'h0000000A, 0, 22);
    bcd_in = 24'h000500;
    start = 1;
    nd = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 20);
      if (c == 3) bcd_in = 24'h777777;
      if (done) begin
        nd++;
        if (nd == 1) begin
          check("rej_latency", c, 22);
          check("rej_result", binary_out, 32'h000001F4);
        end
      end
    end
    check("rej_single_done", nd, 1);
    bcd_in = 24'h654321;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("midrst_out", binary_out, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("midrst_no_done", nd, 0);
    run_conv(24'h000042, 32'h0000002A, 0, 22);
    bcd_in = 24'h000099;
    start = 1;
    last = -1;
    nd = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        check("cont_result", binary_out, 32'h00000063);
        check("cont_timing", c - last, last < 0 ? 23 : 22);
        last = c;
      end
    end
    check("cont_pulses", nd, 3);
    start = 0;
    repeat (30) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
